supercar_scan_decoder: RTL and testbench
========================================

Name: supercar_scan_decoder

Overview:
- Observer at the output end of the Supercar LED scanner.
- Samples the 10-bit LED bar and recovers the lit position and sweep direction.
- Counts direction reversals (bounces) and flags illegal patterns.
- Drives four active-low 7-segment digits for on-board checking, or sits beside the scanner as a synthesizable self-check.

Parameters:
N_LED, 10, LED bar width; only 10 supported by the HEX0 digit map.
ERR_STICKY, 1, 1 = FAULT held until clear or reset; 0 = FAULT exits on the next valid one-hot pattern.

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
KEY  input  4  KEY[0] = async active-low reset; KEY[1] = active-low sync clear of counter and fault; KEY[3:2] unused
LED_IN  input  N_LED  scanner LED bar, same clock domain, bit i = LED i
POS  output  4  last valid lit index 0..9
DIR_UP  output  1  1 = last step was +1, 0 = last step was -1
BOUNCES  output  8  BCD reversal count, {tens,units}, 00..99
ERR  output  1  high while in FAULT
HEX0  output  7  position digit, active-low, bit order {g,f,e,d,c,b,a}
HEX1  output  7  direction glyph
HEX2  output  7  BOUNCES units
HEX3  output  7  BOUNCES tens

Behaviour:
- Reset (KEY[0]=0, asynchronous):
  - Sample and prev registers cleared; state = IDLE.
  - POS=0, DIR_UP=1, BOUNCES=8'h00, ERR=0.
  - HEX0..HEX3 = 7'h3F ('-').
- Input stage: LED_IN registered every cycle into smp; smp is compared with prev (smp of the previous cycle).
- Latency: an LED_IN change at edge k is registered into smp at k; POS, DIR_UP, BOUNCES, ERR and HEX update at edge k+1.
- Pattern classes:
  - ZERO = all bits 0.
  - ONEHOT = exactly one bit set; its index is pos_new.
  - MULTI = two or more bits set.
- States: IDLE, TRACK, FAULT.
  - IDLE: ONEHOT -> POS=pos_new, go TRACK; DIR_UP unchanged, no count. ZERO stays IDLE. MULTI -> FAULT.
  - TRACK, smp==prev: hold all outputs.
  - TRACK, smp!=prev:
    - ONEHOT with pos_new==POS+1: DIR_UP<=1.
    - ONEHOT with pos_new==POS-1: DIR_UP<=0.
    - Either step: POS<=pos_new. If the new direction differs from the old DIR_UP, BOUNCES increments.
    - ONEHOT with any other delta -> FAULT (jump); POS unchanged.
    - ZERO -> IDLE; POS and DIR_UP retained.
    - MULTI -> FAULT.
  - FAULT:
    - ERR=1; POS, DIR_UP and BOUNCES frozen.
    - ERR_STICKY=1: leave only on KEY[1] low or reset.
    - ERR_STICKY=0: next ONEHOT -> TRACK with POS=pos_new, no count.
- KEY[1] low, sampled at the clock edge: BOUNCES<=00, ERR<=0, state<=IDLE; POS and DIR_UP retained.
  - KEY[1] has priority over any same-cycle transition.
  - Held low: block stays in IDLE.
- BOUNCES: BCD increment; 09->10, 99->00 wrap. No saturation.
- First step after IDLE sets direction without a count. The bounce rule compares against the retained DIR_UP, so a reversal relative to it counts.
- HEX digit map (0..9): 40,79,24,30,19,12,02,78,00,10 (hex).
- HEX encoding by state:
  - IDLE: all HEX = 3F.
  - TRACK: HEX0 = digit(POS); HEX1 = 41 ('U') if DIR_UP else 21 ('d'); HEX2/HEX3 = digits of BOUNCES.
  - FAULT: HEX0 = 06 ('E'), HEX1 = 3F, HEX2/HEX3 still show BOUNCES.
- Reset mid-sweep: immediate clear; the decoder re-acquires on the first ONEHOT after release.

Test Plan:
- Reset, then LED_IN 0x001,0x002,0x004 (4 cycles each).
  - Required: POS 0->1->2, DIR_UP=1, BOUNCES=00, HEX0=24, HEX1=41, ERR=0.
- Full sweep 0..9 then back to 0, one step per 4 cycles.
  - Required: at 9->8, BOUNCES=01 and HEX1=21.
  - Required: at 0->1, BOUNCES=02; HEX2=24, HEX3=40.
- 0x010 followed by 0x040 (jump 4->6).
  - Required: ERR=1 two edges later; HEX0=06; POS stays 4.
  - Required: ERR stays 1 through further valid steps until KEY[1] is pulsed low; then ERR=0 and all HEX=3F.
- LED_IN=0x003 from TRACK -> FAULT.
  - Required: then LED_IN=0x000 with KEY[1] low -> IDLE with BOUNCES=00.
- Force 100 reversals (alternate 0x010/0x020).
  - Required: BOUNCES passes 09->10 correctly, 99 wraps to 00.
- Assert KEY[0]=0 mid-sweep, off the clock edge.
  - Required: outputs clear immediately (no clock), HEX=3F.
  - Required: after release, the first ONEHOT 0x080 gives POS=7 with no count.

Source files
------------

// File: rtl/supercar_scan_decoder.sv
// Supercar scan decoder: watches the 10-LED scanner bar, recovers the lit
// position and sweep direction, counts direction reversals in BCD, flags
// illegal patterns and drives four active-low 7-segment digits.
module supercar_scan_decoder #(
  parameter int N_LED      = 10,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic [3:0]       KEY,
  input  logic [N_LED-1:0] LED_IN,
  output logic [3:0]       POS,
  output logic             DIR_UP,
  output logic [7:0]       BOUNCES,
  output logic             ERR,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  logic rst_n;
  logic clr_n;
  logic unused_keys;
  assign rst_n       = KEY[0];
  assign clr_n       = KEY[1];
  assign unused_keys = ^KEY[3:2];

  logic [N_LED-1:0] smp_reg, prev_reg;
  state_t           state_reg, state_next;
  logic [3:0]       pos_reg, pos_next;
  logic             dir_reg, dir_next;
  logic [7:0]       bcd_reg, bcd_next;

  logic       pat_zero, pat_multi, pat_onehot, changed;
  logic [3:0] pos_new;
  logic       step_up, step_dn;
  logic [7:0] bcd_inc;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  endfunction

  // Input stage: register the bar and keep the previous sample for change detection.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      smp_reg  <= '0;
      prev_reg <= '0;
    end else begin
      smp_reg  <= LED_IN;
      prev_reg <= smp_reg;
    end
  end

  // Classify the sample (x & (x-1) is nonzero exactly when two or more bits are set).
  always_comb begin
    pat_zero   = (smp_reg == '0);
    pat_multi  = |(smp_reg & (smp_reg - 1'b1));
    pat_onehot = !pat_zero && !pat_multi;
    changed    = (smp_reg != prev_reg);
    pos_new    = 4'd0;
    for (int i = 0; i < N_LED; i++) begin
      if (smp_reg[i]) pos_new = 4'(i);
    end
    // Widened compare so a step up from 15 can never alias to 0.
    step_up = pat_onehot && ({1'b0, pos_new} == ({1'b0, pos_reg} + 5'd1));
    step_dn = pat_onehot && (pos_reg != 4'd0) && (pos_new == (pos_reg - 4'd1));
    // BCD increment with 99 -> 00 wrap.
    if (bcd_reg[3:0] == 4'd9) begin
      bcd_inc[3:0] = 4'd0;
      bcd_inc[7:4] = (bcd_reg[7:4] == 4'd9) ? 4'd0 : bcd_reg[7:4] + 4'd1;
    end else begin
      bcd_inc[3:0] = bcd_reg[3:0] + 4'd1;
      bcd_inc[7:4] = bcd_reg[7:4];
    end
  end

  // Next-state logic: tracking FSM, with the clear key overriding any transition.
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    dir_next   = dir_reg;
    bcd_next   = bcd_reg;
    case (state_reg)
      IDLE: begin
        if (pat_onehot) begin
          state_next = TRACK;
          pos_next   = pos_new;
        end else if (pat_multi) begin
          state_next = FAULT;
        end
      end
      TRACK: begin
        if (changed) begin
          if (step_up || step_dn) begin
            pos_next = pos_new;
            dir_next = step_up;
            if (step_up != dir_reg) bcd_next = bcd_inc;
          end else if (pat_zero) begin
            state_next = IDLE;
          end else begin
            state_next = FAULT;
          end
        end
      end
      FAULT: begin
        if (!ERR_STICKY && changed && pat_onehot) begin
          state_next = TRACK;
          pos_next   = pos_new;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!clr_n) begin
      state_next = IDLE;
      bcd_next   = 8'h00;
    end
  end

  // State and tracked-value registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pos_reg   <= 4'd0;
      dir_reg   <= 1'b1;
      bcd_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      dir_reg   <= dir_next;
      bcd_reg   <= bcd_next;
    end
  end

  // Output decode: status outputs and per-state 7-segment glyphs.
  always_comb begin
    POS     = pos_reg;
    DIR_UP  = dir_reg;
    BOUNCES = bcd_reg;
    ERR     = (state_reg == FAULT);
    HEX0    = 7'h3F;
    HEX1    = 7'h3F;
    HEX2    = 7'h3F;
    HEX3    = 7'h3F;
    case (state_reg)
      TRACK: begin
        HEX0 = seg7(pos_reg);
        HEX1 = dir_reg ? 7'h41 : 7'h21;
        HEX2 = seg7(bcd_reg[3:0]);
        HEX3 = seg7(bcd_reg[7:4]);
      end
      FAULT: begin
        HEX0 = 7'h06;
        HEX2 = seg7(bcd_reg[3:0]);
        HEX3 = seg7(bcd_reg[7:4]);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_supercar_scan_decoder.sv
module tb_supercar_scan_decoder;

    localparam int S_IDLE  = 0;
    localparam int S_TRACK = 1;
    localparam int S_FAULT = 2;

    logic       CLOCK_50;
    logic [3:0] KEY;
    logic [9:0] LED_IN;
    logic [3:0] POS;
    logic       DIR_UP;
    logic [7:0] BOUNCES;
    logic       ERR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    supercar_scan_decoder #(.N_LED(10), .ERR_STICKY(1'b1)) dut (
        .CLOCK_50(CLOCK_50),
        .KEY(KEY),
        .LED_IN(LED_IN),
        .POS(POS),
        .DIR_UP(DIR_UP),
        .BOUNCES(BOUNCES),
        .ERR(ERR),
        .HEX0(HEX0),
        .HEX1(HEX1),
        .HEX2(HEX2),
        .HEX3(HEX3)
    );

    typedef struct {
        int          due;
        string       name;
        logic [41:0] exp;
    } item_t;

    item_t sb_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    sb_checks = 0;
    int    sb_pass = 0;
    event  chk_ev;
    logic [6:0] seg_tab [10];

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    end

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [41:0] expv(input int st, input int pos, input bit dir, input int cnt);
        logic [6:0] h0, h1, h2, h3;
        logic [7:0] b;
        b  = {4'(cnt / 10), 4'(cnt % 10)};
        h0 = 7'h3F; h1 = 7'h3F; h2 = 7'h3F; h3 = 7'h3F;
        if (st == S_TRACK) begin
            h0 = seg_tab[pos];
            h1 = dir ? 7'h41 : 7'h21;
            h2 = seg_tab[cnt % 10];
            h3 = seg_tab[cnt / 10];
        end else if (st == S_FAULT) begin
            h0 = 7'h06;
            h2 = seg_tab[cnt % 10];
            h3 = seg_tab[cnt / 10];
        end
        return {4'(pos), dir, b, (st == S_FAULT), h3, h2, h1, h0};
    endfunction

    task automatic push(input int due, input string nm, input logic [41:0] e);
        item_t it;
        it.due  = due;
        it.name = nm;
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    task automatic drive(input logic [9:0] led, input logic k1, input int hold,
                         input string nm, input logic [41:0] e);
        @(posedge CLOCK_50);
        #2;
        LED_IN = led;
        KEY[1] = k1;
        push(cyc + 2, nm, e);
        repeat (hold - 1) @(posedge CLOCK_50);
    endtask

    initial begin
        item_t       it;
        logic [41:0] act;
        forever begin
            @(negedge CLOCK_50 or chk_ev);
            while (sb_q.size() > 0 && (sb_q[0].due < 0 || sb_q[0].due <= cyc)) begin
                it  = sb_q.pop_front();
                act = {POS, DIR_UP, BOUNCES, ERR, HEX3, HEX2, HEX1, HEX0};
                n_checks++;
                sb_checks++;
                if (act === it.exp) begin
                    n_pass++;
                    sb_pass++;
                    $display("check %s ok: pos=%0d dir=%0d bcd=%h err=%0d hex=%h_%h_%h_%h",
                             it.name, POS, DIR_UP, BOUNCES, ERR, HEX3, HEX2, HEX1, HEX0);
                end else begin
                    $display("FAIL %s: got pos=%0d dir=%0d bcd=%h err=%0d hex=%h_%h_%h_%h, want pos=%0d dir=%0d bcd=%h err=%0d hex=%h_%h_%h_%h",
                             it.name, POS, DIR_UP, BOUNCES, ERR, HEX3, HEX2, HEX1, HEX0,
                             it.exp[41:38], it.exp[37], it.exp[36:29], it.exp[28],
                             it.exp[27:21], it.exp[20:14], it.exp[13:7], it.exp[6:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        KEY    = 4'b1111;
        LED_IN = 10'h000;

        #3;
        KEY[0] = 1'b0;
        #1;
        n_checks++;
        if (POS === 4'd0 && DIR_UP === 1'b1) begin
            n_pass++;
            $display("check direct_reset_pos ok: pos=%0d dir=%0d", POS, DIR_UP);
        end else begin
            $display("FAIL direct_reset_pos: got pos=%0d dir=%0d, want pos=0 dir=1", POS, DIR_UP);
        end
        n_checks++;
        if (BOUNCES === 8'h00 && ERR === 1'b0) begin
            n_pass++;
            $display("check direct_reset_cnt ok: bcd=%h err=%0d", BOUNCES, ERR);
        end else begin
            $display("FAIL direct_reset_cnt: got bcd=%h err=%0d, want bcd=00 err=0", BOUNCES, ERR);
        end
        n_checks++;
        if (HEX0 === 7'h3F && HEX1 === 7'h3F && HEX2 === 7'h3F && HEX3 === 7'h3F) begin
            n_pass++;
            $display("check direct_reset_hex ok: hex=%h_%h_%h_%h", HEX3, HEX2, HEX1, HEX0);
        end else begin
            $display("FAIL direct_reset_hex: got hex=%h_%h_%h_%h, want 3f_3f_3f_3f", HEX3, HEX2, HEX1, HEX0);
        end
        push(-1, "reset", expv(S_IDLE, 0, 1'b1, 0));
        ->chk_ev;
        repeat (2) @(posedge CLOCK_50);
        #2;
        KEY[0] = 1'b1;

        drive(10'h001, 1'b1, 4, "acq0", expv(S_TRACK, 0, 1'b1, 0));
        drive(10'h002, 1'b1, 4, "up1",  expv(S_TRACK, 1, 1'b1, 0));
        drive(10'h004, 1'b1, 4, "up2",  expv(S_TRACK, 2, 1'b1, 0));

        for (int p = 3; p <= 9; p++)
            drive(10'(1 << p), 1'b1, 4, $sformatf("sweep_up%0d", p), expv(S_TRACK, p, 1'b1, 0));
        for (int p = 8; p >= 0; p--)
            drive(10'(1 << p), 1'b1, 4, $sformatf("sweep_dn%0d", p), expv(S_TRACK, p, 1'b0, 1));
        drive(10'h002, 1'b1, 4, "bounce2", expv(S_TRACK, 1, 1'b1, 2));

        drive(10'h004, 1'b1, 4, "walk2",  expv(S_TRACK, 2, 1'b1, 2));
        drive(10'h008, 1'b1, 4, "walk3",  expv(S_TRACK, 3, 1'b1, 2));
        drive(10'h010, 1'b1, 4, "walk4",  expv(S_TRACK, 4, 1'b1, 2));
        drive(10'h040, 1'b1, 4, "jump",   expv(S_FAULT, 4, 1'b1, 2));
        drive(10'h020, 1'b1, 4, "stick5", expv(S_FAULT, 4, 1'b1, 2));
        drive(10'h010, 1'b1, 4, "stick4", expv(S_FAULT, 4, 1'b1, 2));
        drive(10'h010, 1'b0, 4, "clear",  expv(S_IDLE,  4, 1'b1, 0));
        drive(10'h010, 1'b1, 4, "reacq",  expv(S_TRACK, 4, 1'b1, 0));

        drive(10'h003, 1'b1, 4, "multi",      expv(S_FAULT, 4, 1'b1, 0));
        drive(10'h000, 1'b0, 4, "clear_zero", expv(S_IDLE,  4, 1'b1, 0));
        drive(10'h000, 1'b1, 4, "idle_zero",  expv(S_IDLE,  4, 1'b1, 0));

        drive(10'h010, 1'b1, 4, "rev_acq", expv(S_TRACK, 4, 1'b1, 0));
        for (int i = 1; i <= 101; i++) begin
            if (i % 2 == 1)
                drive(10'h020, 1'b1, 1, $sformatf("rev%0d", i), expv(S_TRACK, 5, 1'b1, (i - 1) % 100));
            else
                drive(10'h010, 1'b1, 1, $sformatf("rev%0d", i), expv(S_TRACK, 4, 1'b0, (i - 1) % 100));
        end
        drive(10'h010, 1'b1, 4, "mid_sweep", expv(S_TRACK, 4, 1'b0, 1));

        @(posedge CLOCK_50);
        #3;
        KEY[0] = 1'b0;
        LED_IN = 10'h000;
        #1;
        n_checks++;
        if (POS === 4'd0 && DIR_UP === 1'b1 && BOUNCES === 8'h00 && ERR === 1'b0) begin
            n_pass++;
            $display("check direct_async_status ok: pos=%0d dir=%0d bcd=%h err=%0d", POS, DIR_UP, BOUNCES, ERR);
        end else begin
            $display("FAIL direct_async_status: got pos=%0d dir=%0d bcd=%h err=%0d, want 0 1 00 0", POS, DIR_UP, BOUNCES, ERR);
        end
        n_checks++;
        if (HEX0 === 7'h3F && HEX1 === 7'h3F && HEX2 === 7'h3F && HEX3 === 7'h3F) begin
            n_pass++;
            $display("check direct_async_hex ok: hex=%h_%h_%h_%h", HEX3, HEX2, HEX1, HEX0);
        end else begin
            $display("FAIL direct_async_hex: got hex=%h_%h_%h_%h, want 3f_3f_3f_3f", HEX3, HEX2, HEX1, HEX0);
        end
        push(-1, "async_reset", expv(S_IDLE, 0, 1'b1, 0));
        ->chk_ev;
        repeat (3) @(posedge CLOCK_50);
        #2;
        KEY[0] = 1'b1;
        drive(10'h080, 1'b1, 4, "reacq7", expv(S_TRACK, 7, 1'b1, 0));

        repeat (5) @(posedge CLOCK_50);
        while (sb_q.size() > 0) begin
            item_t it;
            it = sb_q.pop_front();
            n_checks++;
            $display("FAIL %s: never compared, due cycle %0d, now %0d", it.name, it.due, cyc);
        end
        n_checks++;
        if (sb_checks > 0 && sb_pass === sb_checks) begin
            n_pass++;
            $display("check scoreboard_all ok: %0d/%0d", sb_pass, sb_checks);
        end else begin
            $display("FAIL scoreboard_all: %0d/%0d scoreboard checks passed", sb_pass, sb_checks);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
